// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Brief    : Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control FSM with fetch
//            timeout trap, multi-cycle execute stall, halt/trap handling and a
//            saturating retired-instruction counter. Optional single-step mode
//            is compiled in when SEQ_SINGLE_STEP_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module cpu_sequencer #(
    parameter int CNT_WIDTH     = 16,
    parameter int FETCH_TIMEOUT = 15,
    parameter int TO_WIDTH      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                 i_step_mode,
    input  logic                 i_step,
`endif
    input  logic                 i_run,
    input  logic                 i_halt_req,
    input  logic                 i_clear,
    input  logic                 i_imem_ack,
    input  logic                 i_illegal,
    input  logic                 i_reg_write,
    input  logic                 i_ex_multi,
    input  logic                 i_ex_done,
    output logic                 o_imem_req,
    output logic                 o_ir_load,
    output logic                 o_pc_en,
    output logic                 o_rf_we,
    output logic [2:0]           o_state,
    output logic                 o_halted,
    output logic                 o_trap,
    output logic [1:0]           o_trap_cause,
    output logic [CNT_WIDTH-1:0] o_retired
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALTED    = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    localparam logic [TO_WIDTH-1:0]  c_to_last   = TO_WIDTH'(FETCH_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] c_ret_max   = '1;
    localparam logic [1:0]           c_cause_none = 2'b00;
    localparam logic [1:0]           c_cause_to   = 2'b01;
    localparam logic [1:0]           c_cause_ill  = 2'b10;

    state_t                 state_q,     state_d;
    logic [TO_WIDTH-1:0]    to_cnt_q,    to_cnt_d;
    logic [1:0]             cause_q,     cause_d;
    logic [CNT_WIDTH-1:0]   retired_q,   retired_d;
    logic                   halt_pend_q, halt_pend_d;
    logic                   ex_busy_q,   ex_busy_d;

    logic                   w_issue;
    logic                   w_wb_stop;
    logic                   w_ex_finish;
    logic                   w_enter_halt;

`ifdef SEQ_SINGLE_STEP_EN
    // Step mode issues one instruction per i_step and always parks in IDLE after it.
    assign w_issue   = i_run & (~i_step_mode | i_step);
    assign w_wb_stop = ~i_run | i_step_mode;
`else
    assign w_issue   = i_run;
    assign w_wb_stop = ~i_run;
`endif

    // A done seen in the entry cycle finishes the op even when it is multi-cycle.
    assign w_ex_finish = ex_busy_q ? i_ex_done : (~i_ex_multi | i_ex_done);

    always_comb begin
        state_d   = state_q;
        to_cnt_d  = '0;
        cause_d   = cause_q;
        retired_d = retired_q;
        ex_busy_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (halt_pend_q) begin
                    state_d = S_HALTED;
                end else if (w_issue) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                if (i_imem_ack) begin
                    state_d = S_DECODE;
                end else if (to_cnt_q == c_to_last) begin
                    state_d = S_TRAP;
                    cause_d = c_cause_to;
                end else begin
                    to_cnt_d = to_cnt_q + TO_WIDTH'(1);
                end
            end

            S_DECODE: begin
                if (i_illegal) begin
                    state_d = S_TRAP;
                    cause_d = c_cause_ill;
                end else begin
                    state_d = S_EXECUTE;
                end
            end

            S_EXECUTE: begin
                if (w_ex_finish) begin
                    state_d = S_WRITEBACK;
                end else begin
                    ex_busy_d = 1'b1;
                end
            end

            S_WRITEBACK: begin
                if (retired_q != c_ret_max) begin
                    retired_d = retired_q + CNT_WIDTH'(1);
                end
                if (halt_pend_q) begin
                    state_d = S_HALTED;
                end else if (w_wb_stop) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_HALTED, S_TRAP: begin
                if (i_clear) begin
                    state_d = S_IDLE;
                    cause_d = c_cause_none;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Halt requests are sticky from any state and consumed only on HALTED entry.
    assign w_enter_halt = (state_d == S_HALTED) && (state_q != S_HALTED);
    assign halt_pend_d  = (halt_pend_q | i_halt_req) & ~w_enter_halt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            to_cnt_q    <= '0;
            cause_q     <= c_cause_none;
            retired_q   <= '0;
            halt_pend_q <= 1'b0;
            ex_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            cause_q     <= cause_d;
            retired_q   <= retired_d;
            halt_pend_q <= halt_pend_d;
            ex_busy_q   <= ex_busy_d;
        end
    end

    assign o_imem_req   = (state_q == S_FETCH);
    assign o_ir_load    = (state_q == S_FETCH) & i_imem_ack;
    assign o_pc_en      = (state_q == S_WRITEBACK);
    assign o_rf_we      = (state_q == S_WRITEBACK) & i_reg_write;
    assign o_state      = state_q;
    assign o_halted     = (state_q == S_HALTED);
    assign o_trap       = (state_q == S_TRAP);
    assign o_trap_cause = cause_q;
    assign o_retired    = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// Self-checking bench for cpu_sequencer: instruction-level records are expanded
// into a per-cycle table of stimulus and expected outputs, then applied in order.
module tb_cpu_sequencer;

    localparam int CW = 4;
    localparam int FT = 4;
    localparam int TW = 3;
    localparam int RET_MAX = (1 << CW) - 1;

    localparam bit [2:0] ST_IDLE = 3'd0;
    localparam bit [2:0] ST_FETCH = 3'd1;
    localparam bit [2:0] ST_DECODE = 3'd2;
    localparam bit [2:0] ST_EXEC = 3'd3;
    localparam bit [2:0] ST_WB = 3'd4;
    localparam bit [2:0] ST_HALT = 3'd5;
    localparam bit [2:0] ST_TRAP = 3'd6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_run = 1'b0, i_halt_req = 1'b0, i_clear = 1'b0, i_imem_ack = 1'b0;
    logic          i_illegal = 1'b0, i_reg_write = 1'b0, i_ex_multi = 1'b0, i_ex_done = 1'b0;
    logic          o_imem_req, o_ir_load, o_pc_en, o_rf_we, o_halted, o_trap;
    logic [2:0]    o_state;
    logic [1:0]    o_trap_cause;
    logic [CW-1:0] o_retired;

    always #5 clk = ~clk;

    cpu_sequencer #(.CNT_WIDTH(CW), .FETCH_TIMEOUT(FT), .TO_WIDTH(TW)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef SEQ_SINGLE_STEP_EN
        .i_step_mode  (1'b0),
        .i_step       (1'b0),
`endif
        .i_run        (i_run),
        .i_halt_req   (i_halt_req),
        .i_clear      (i_clear),
        .i_imem_ack   (i_imem_ack),
        .i_illegal    (i_illegal),
        .i_reg_write  (i_reg_write),
        .i_ex_multi   (i_ex_multi),
        .i_ex_done    (i_ex_done),
        .o_imem_req   (o_imem_req),
        .o_ir_load    (o_ir_load),
        .o_pc_en      (o_pc_en),
        .o_rf_we      (o_rf_we),
        .o_state      (o_state),
        .o_halted     (o_halted),
        .o_trap       (o_trap),
        .o_trap_cause (o_trap_cause),
        .o_retired    (o_retired)
    );

    // One clock cycle: inputs to drive and the state/cause expected while they are applied.
    typedef struct {
        bit       run, halt, clr, ack, ill, multi, done, regw;
        bit [2:0] st;
        bit [1:0] cause;
    } cyc_t;

    // One instruction: ack delay (>=FT means never), exec length (0 = single-cycle op).
    typedef struct {
        int ad;
        int ml;
        bit ill;
        bit regw;
        int halt_at;
        bit run_after;
    } ins_t;

    cyc_t tl[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc_idx = 0;
    int   cur_k = 0;
    int   cur_halt = -1;
    bit   g_hp = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc_idx, act, exp);
        end
    endtask

    // Inputs a state does not sample are randomised to expose wrong sampling windows.
    function automatic cyc_t mk(input bit [2:0] st);
        cyc_t c;
        c.run   = 1'($urandom);
        c.clr   = 1'($urandom);
        c.ack   = 1'($urandom);
        c.ill   = 1'($urandom);
        c.multi = 1'($urandom);
        c.done  = 1'($urandom);
        c.regw  = 1'($urandom);
        c.halt  = 1'b0;
        c.st    = st;
        c.cause = 2'b00;
        return c;
    endfunction

    function automatic void push(input cyc_t c);
        cyc_t t = c;
        if (cur_k == cur_halt) begin
            t.halt = 1'b1;
            g_hp   = 1'b1;
        end
        cur_k++;
        tl.push_back(t);
    endfunction

    function automatic void halted_seq();
        cyc_t c;
        int   n = $urandom_range(0, 2);
        g_hp = 1'b0;
        for (int i = 0; i < n; i++) begin
            c = mk(ST_HALT); c.clr = 1'b0; push(c);
        end
        c = mk(ST_HALT); c.clr = 1'b1; push(c);
    endfunction

    function automatic void idle_run();
        cyc_t c;
        int   n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            c = mk(ST_IDLE); c.run = 1'b0; push(c);
        end
        c = mk(ST_IDLE); c.run = 1'b1; push(c);
    endfunction

    function automatic void goto_idle();
        cyc_t c;
        if (g_hp) begin
            c = mk(ST_IDLE); push(c);
            halted_seq();
        end
        idle_run();
    endfunction

    function automatic void trap_seq(input bit [1:0] cause);
        cyc_t c;
        int   n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            c = mk(ST_TRAP); c.clr = 1'b0; c.cause = cause; push(c);
        end
        c = mk(ST_TRAP); c.clr = 1'b1; c.cause = cause; push(c);
    endfunction

    // Expands one instruction starting in FETCH, plus whatever follows its boundary.
    function automatic void gen_instr(input ins_t p);
        cyc_t     c;
        bit       trapped = 1'b0;
        bit [1:0] cause = 2'b00;
        cur_k    = 0;
        cur_halt = p.halt_at;
        if (p.ad >= FT) begin
            for (int i = 0; i < FT; i++) begin
                c = mk(ST_FETCH); c.ack = 1'b0; push(c);
            end
            trapped = 1'b1; cause = 2'b01;
        end else begin
            for (int i = 0; i < p.ad; i++) begin
                c = mk(ST_FETCH); c.ack = 1'b0; push(c);
            end
            c = mk(ST_FETCH); c.ack = 1'b1; push(c);
            c = mk(ST_DECODE); c.ill = p.ill; push(c);
            if (p.ill) begin
                trapped = 1'b1; cause = 2'b10;
            end else begin
                if (p.ml == 0) begin
                    c = mk(ST_EXEC); c.multi = 1'b0; push(c);
                end else begin
                    for (int j = 1; j <= p.ml; j++) begin
                        c = mk(ST_EXEC);
                        if (j == 1) c.multi = 1'b1;
                        c.done = (j == p.ml);
                        push(c);
                    end
                end
                c = mk(ST_WB); c.regw = p.regw; c.run = p.run_after; push(c);
            end
        end
        cur_halt = -1;
        if (trapped) begin
            trap_seq(cause);
            goto_idle();
        end else if (g_hp) begin
            halted_seq();
            idle_run();
        end else if (!p.run_after) begin
            idle_run();
        end
    endfunction

    ins_t dir[10];
    ins_t rp;
    cyc_t c;
    int   exp_ret;

    initial begin
        dir[0] = '{0, 0, 1'b0, 1'b1, -1, 1'b1};
        dir[1] = '{0, 0, 1'b0, 1'b1, -1, 1'b1};
        dir[2] = '{0, 0, 1'b0, 1'b1, -1, 1'b1};
        dir[3] = '{0, 5, 1'b0, 1'b1, -1, 1'b1};
        dir[4] = '{1, 1, 1'b0, 1'b0, -1, 1'b1};
        dir[5] = '{FT, 0, 1'b0, 1'b1, -1, 1'b1};
        dir[6] = '{0, 0, 1'b1, 1'b1, -1, 1'b1};
        dir[7] = '{0, 3, 1'b0, 1'b1, 3, 1'b1};
        dir[8] = '{FT - 1, 0, 1'b0, 1'b1, -1, 1'b1};
        dir[9] = '{2, 2, 1'b0, 1'b0, -1, 1'b0};

        // First IDLE cycle goes straight to FETCH so WB lands on cycles 4, 8, 12.
        c = mk(ST_IDLE); c.run = 1'b1; push(c);
        for (int i = 0; i < 10; i++) gen_instr(dir[i]);
        for (int i = 0; i < 70; i++) begin
            rp.ad        = ($urandom_range(0, 9) == 0) ? FT : $urandom_range(0, FT - 1);
            rp.ml        = $urandom_range(0, 4);
            rp.ill       = ($urandom_range(0, 9) == 0);
            rp.regw      = 1'($urandom);
            rp.halt_at   = ($urandom_range(0, 6) == 0) ? $urandom_range(0, rp.ad + 1) : -1;
            rp.run_after = ($urandom_range(0, 4) != 0);
            gen_instr(rp);
        end

        #1 rst = 1'b0;
        #2;
        chk("rst_state", o_state, 0);
        chk("rst_imem_req", o_imem_req, 0);
        chk("rst_pc_en", o_pc_en, 0);
        chk("rst_retired", o_retired, 0);
        chk("rst_cause", o_trap_cause, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        exp_ret = 0;
        for (int i = 0; i < tl.size(); i++) begin
            cyc_idx     = i;
            c           = tl[i];
            i_run       = c.run;
            i_halt_req  = c.halt;
            i_clear     = c.clr;
            i_imem_ack  = c.ack;
            i_illegal   = c.ill;
            i_ex_multi  = c.multi;
            i_ex_done   = c.done;
            i_reg_write = c.regw;
            #1;
            chk("state", o_state, c.st);
            chk("imem_req", o_imem_req, c.st == ST_FETCH);
            chk("ir_load", o_ir_load, (c.st == ST_FETCH) && c.ack);
            chk("pc_en", o_pc_en, c.st == ST_WB);
            chk("rf_we", o_rf_we, (c.st == ST_WB) && c.regw);
            chk("halted", o_halted, c.st == ST_HALT);
            chk("trap", o_trap, c.st == ST_TRAP);
            chk("trap_cause", o_trap_cause, c.cause);
            chk("retired", o_retired, exp_ret);
            if (c.st == ST_WB && exp_ret < RET_MAX) exp_ret++;
            @(negedge clk);
        end

        // Every generated flow ends heading into FETCH; reset must act without a clock edge.
        cyc_idx    = tl.size();
        i_run      = 1'b1;
        i_imem_ack = 1'b0;
        i_halt_req = 1'b0;
        i_clear    = 1'b0;
        #1;
        chk("pre_async_state", o_state, ST_FETCH);
        chk("pre_async_retired", o_retired, exp_ret);
        #1 rst = 1'b0;
        #1;
        chk("async_state", o_state, 0);
        chk("async_imem_req", o_imem_req, 0);
        chk("async_retired", o_retired, 0);
        chk("async_cause", o_trap_cause, 0);
        @(negedge clk);
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
